piso_tx: RTL and testbench



---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_tx_serial_bit_counter.sv | 41 ++++
 rtl/piso_tx.sv | 150 +++++++++++++++
 tb/tb_piso_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the piso_tx parallel-in serial-out transmitter:
// FSM state encoding and the bit-counter width helper.
package piso_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // Counter must hold values up to WIDTH (the parity slot) when parity is on.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_tx_serial_bit_counter.sv
// Modulo-MOD frame bit counter with synchronous clear, increment enable and
// terminal-count flag marking the final bit of a frame.
module serial_bit_counter #(
  parameter int MOD = 4,
  parameter int CW  = 3
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc    = (count_q == CW'(MOD - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (tc) begin
        count_d = {CW{1'b0}};
      end else begin
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and gap-free framing.
// Optional trailing even-parity bit enabled by defining PISO_TX_PARITY_EN.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_first,
  output logic             so_last,
  output logic             busy
);

`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = cnt_width(WIDTH);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_s;
  logic             tc_s;
  logic             accept_s;
  logic             busy_s;
  logic             data_last_s;
  logic             data_bit_s;
`ifdef PISO_TX_PARITY_EN
  logic             par_q;
  logic             par_d;
`endif

  assign busy_s      = (state_q != ST_IDLE);
  assign load_ready  = (state_q == ST_IDLE) | tc_s;
  assign accept_s    = load_valid & load_ready;
  assign data_last_s = (cnt_s == CW'(WIDTH - 1));
  assign data_bit_s  = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

  serial_bit_counter #(
    .MOD (FL),
    .CW  (CW)
  ) u_cnt (
    .clk   (clk),
    .clear (clear),
    .en    (busy_s),
    .count (cnt_s),
    .tc    (tc_s)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
`ifdef PISO_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (data_last_s) begin
`ifdef PISO_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = accept_s ? ST_SHIFT : ST_IDLE;
`endif
        end else begin
          state_d = ST_SHIFT;
        end
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        state_d = accept_s ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new word overrides the drain; the register is empty once a frame ends.
  always_comb begin
    shreg_d = shreg_q;
    if (accept_s) begin
      shreg_d = pi;
    end else if (state_q == ST_SHIFT) begin
      if (MSB_FIRST != 0) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
    end else begin
      shreg_d = shreg_q;
    end
`ifdef PISO_TX_PARITY_EN
    par_d = accept_s ? (^pi) : par_q;
`endif
  end

  always_comb begin
    so       = 1'b0;
    so_first = 1'b0;
    case (state_q)
      ST_SHIFT: begin
        so       = data_bit_s;
        so_first = (cnt_s == {CW{1'b0}});
      end
`ifdef PISO_TX_PARITY_EN
      ST_PARITY: begin
        so = par_q;
      end
`endif
      default: begin
        so       = 1'b0;
        so_first = 1'b0;
      end
    endcase
    so_valid = busy_s;
    so_last  = tc_s;
    busy     = busy_s;
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed vector table, continuous-stream
// sequence and randomized traffic against a queue-based frame model.
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] pi = 4'd0;
  logic       load_valid = 1'b0;
  logic       rdy_m, so_m, v_m, f_m, l_m, b_m;
  logic       rdy_l, so_l, v_l, f_l, l_l, b_l;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .clear(clear), .pi(pi), .load_valid(load_valid),
    .load_ready(rdy_m), .so(so_m), .so_valid(v_m), .so_first(f_m),
    .so_last(l_m), .busy(b_m));

  piso_tx #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .clear(clear), .pi(pi), .load_valid(load_valid),
    .load_ready(rdy_l), .so(so_l), .so_valid(v_l), .so_first(f_l),
    .so_last(l_l), .busy(b_l));

  // Reference: remaining bits of the frame currently on the wire.
  bit qm[$];
  bit ql[$];
  int pos = 0;

  typedef struct {
    logic       c;
    logic       lv;
    logic [3:0] p;
    logic [5:0] em;
    logic [5:0] el;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic c, input logic lv, input logic [3:0] p,
                              input logic r, input logic v, input logic f,
                              input logic l, input logic sm, input logic sl);
    vec_t t;
    t.c = c; t.lv = lv; t.p = p;
    t.em = {r, v, f, l, v, sm};
    t.el = {r, v, f, l, v, sl};
    return t;
  endfunction

  function automatic logic [5:0] obs_m();
    return {rdy_m, v_m, f_m, l_m, b_m, so_m};
  endfunction

  function automatic logic [5:0] obs_l();
    return {rdy_l, v_l, f_l, l_l, b_l, so_l};
  endfunction

  task automatic cmp(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got {rdy,v,f,l,busy,so}=%b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic apply(input logic c, input logic lv, input logic [3:0] p);
    clear = c; load_valid = lv; pi = p;
    #1;
  endtask

  // Compare DUTs with the model, then clock the edge and advance the model.
  task automatic advance();
    logic r, v, f, l, sm, sl, acc;
    v  = (qm.size() > 0);
    sm = v ? qm[0] : 1'b0;
    sl = v ? ql[0] : 1'b0;
    f  = v && (pos == 0);
    l  = (qm.size() == 1);
    r  = (qm.size() <= 1);
    cmp("model_msb", obs_m(), {r, v, f, l, v, sm});
    cmp("model_lsb", obs_l(), {r, v, f, l, v, sl});
    acc = load_valid && r;
    @(posedge clk);
    if (clear) begin
      qm.delete(); ql.delete(); pos = 0;
    end else begin
      if (qm.size() > 0) begin
        void'(qm.pop_front()); void'(ql.pop_front()); pos++;
      end
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          qm.push_back(pi[3-i]);
          ql.push_back(pi[i]);
        end
`ifdef PISO_TX_PARITY_EN
        qm.push_back(^pi);
        ql.push_back(^pi);
`endif
        pos = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int vcount;

`ifdef PISO_TX_PARITY_EN
    tbl.push_back(mk(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`else
    tbl.push_back(mk(1'b1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
`endif

    // First reset edge: outputs are undefined before it, so only advance.
    apply(1'b1, 1'b1, 4'hF);
    @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      apply(tbl[i].c, tbl[i].lv, tbl[i].p);
      cmp($sformatf("vec%0d_msb", i), obs_m(), tbl[i].em);
      cmp($sformatf("vec%0d_lsb", i), obs_l(), tbl[i].el);
      advance();
    end

    // Continuous load_valid must give 3*FL unbroken valid cycles.
    vcount = 0;
    for (int k = 0; k <= 3 * FL; k++) begin
      apply(1'b0, 1'b1, 4'($urandom_range(0, 15)));
      if (k > 0 && v_m === 1'b1) vcount++;
      advance();
    end
    apply(1'b0, 1'b0, 4'h0);
    checks++;
    if (vcount != 3 * FL) begin
      errs++;
      $display("FAIL stream_contiguous: got %0d valid cycles expected %0d", vcount, 3 * FL);
    end
    for (int k = 0; k < FL + 1; k++) advance();

    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
            4'($urandom_range(0, 15)));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
